// File: rtl/edge_router_sequencer_pkg.sv
// Shared register map, STATUS bit positions and sequencer state encoding
// for the edge-detection router select sequencer.
package edge_router_sequencer_pkg;

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_FRAMES  = 2'd2;
   localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

   localparam int CTRL_REQ_SEL = 0;
   localparam int CTRL_IRQ_EN  = 1;

   localparam int STAT_ACTIVE  = 0;
   localparam int STAT_PENDING = 1;
   localparam int STAT_DONE    = 2;
   localparam int STAT_TMO     = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_EOP = 2'd1,
      DRAIN    = 2'd2,
      SWITCH   = 2'd3
   } seq_state_e;

endpackage

// File: rtl/edge_router_sequencer_if.sv
// Avalon-MM control port plus the monitored Avalon-ST handshake and the
// router controls driven back towards the video-in path.
interface edge_router_sequencer_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        st_valid;
   logic        st_ready;
   logic        st_sop;
   logic        st_eop;
   logic        st_hold;
   logic        router_select;
   logic        irq;

   modport master (
      output address, chipselect, read, write, writedata,
      output st_valid, st_ready, st_sop, st_eop,
      input  readdata, st_hold, router_select, irq
   );

   modport slave (
      input  address, chipselect, read, write, writedata,
      input  st_valid, st_ready, st_sop, st_eop,
      output readdata, st_hold, router_select, irq
   );

endinterface

// File: rtl/edge_router_sequencer_stream_frame_tracker.sv
// Watches the upstream Avalon-ST handshake: tracks whether a frame is open,
// flags end-of-packet beats and counts them with saturation.
module stream_frame_tracker #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             st_valid_i,
   input  logic             st_ready_i,
   input  logic             st_sop_i,
   input  logic             st_eop_i,
   input  logic             clr_i,
   output logic             in_frame_o,
   output logic             eop_beat_o,
   output logic [CNT_W-1:0] frames_o
);

   logic             beat;
   logic             in_frame_q, in_frame_d;
   logic [CNT_W-1:0] frames_q, frames_d;

   assign beat       = st_valid_i & st_ready_i;
   assign eop_beat_o = beat & st_eop_i;
   assign in_frame_o = in_frame_q;
   assign frames_o   = frames_q;

   // eop dominates so a single-beat sop+eop frame never leaves the flag set
   always_comb begin
      in_frame_d = in_frame_q;
      if (beat) begin
         if (st_eop_i)      in_frame_d = 1'b0;
         else if (st_sop_i) in_frame_d = 1'b1;
      end
      frames_d = frames_q;
      if (clr_i)                                 frames_d = '0;
      else if (eop_beat_o && (frames_q != '1))   frames_d = frames_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_frame_q <= 1'b0;
         frames_q   <= '0;
      end else begin
         in_frame_q <= in_frame_d;
         frames_q   <= frames_d;
      end
   end

endmodule

// File: rtl/edge_router_sequencer.sv
// Applies software-requested router path changes only at frame boundaries:
// waits for EOP, holds upstream, drains the edge-detect pipeline, then flips.
module edge_router_sequencer
   import edge_router_sequencer_pkg::*;
#(
   parameter int DRAIN_CYCLES = 16,
   parameter int CNT_W        = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   edge_router_sequencer_if.slave   bus
);

   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   seq_state_e       state_q;
   logic [DW-1:0]    drain_cnt_q;
   logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_inc, timeout_q, frames;
   logic             req_sel_q, irq_en_q, router_select_q, st_hold_q;
   logic             done_q, tmo_err_q;
   logic [31:0]      readdata_q, rd_mux;
   logic             wr_ctrl, wr_status, wr_timeout, rd_en;
   logic             in_frame, eop_beat, switch_req, tmo_hit;
   logic             unused_wdata;

   stream_frame_tracker #(.CNT_W(CNT_W)) u_tracker (
      .clk        (clk),
      .reset      (reset),
      .st_valid_i (bus.st_valid),
      .st_ready_i (bus.st_ready),
      .st_sop_i   (bus.st_sop),
      .st_eop_i   (bus.st_eop),
      .clr_i      (state_q == SWITCH),
      .in_frame_o (in_frame),
      .eop_beat_o (eop_beat),
      .frames_o   (frames)
   );

   assign wr_ctrl     = bus.chipselect & bus.write & (bus.address == ADDR_CTRL);
   assign wr_status   = bus.chipselect & bus.write & (bus.address == ADDR_STATUS);
   assign wr_timeout  = bus.chipselect & bus.write & (bus.address == ADDR_TIMEOUT);
   assign rd_en       = bus.chipselect & bus.read;
   assign switch_req  = req_sel_q != router_select_q;
   assign tmo_cnt_inc = tmo_cnt_q + 1'b1;
   assign tmo_hit     = (timeout_q != '0) && (tmo_cnt_inc == timeout_q);
   assign unused_wdata = ^bus.writedata;

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         ADDR_CTRL: begin
            rd_mux[CTRL_REQ_SEL] = req_sel_q;
            rd_mux[CTRL_IRQ_EN]  = irq_en_q;
         end
         ADDR_STATUS: begin
            rd_mux[STAT_ACTIVE]  = router_select_q;
            rd_mux[STAT_PENDING] = state_q != IDLE;
            rd_mux[STAT_DONE]    = done_q;
            rd_mux[STAT_TMO]     = tmo_err_q;
         end
         ADDR_FRAMES: rd_mux[CNT_W-1:0] = frames;
         default:     rd_mux[CNT_W-1:0] = timeout_q;
      endcase
   end

   // FSM updates follow the W1C clears so a same-cycle set wins
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         drain_cnt_q     <= '0;
         tmo_cnt_q       <= '0;
         timeout_q       <= '0;
         req_sel_q       <= 1'b0;
         irq_en_q        <= 1'b0;
         router_select_q <= 1'b0;
         st_hold_q       <= 1'b0;
         done_q          <= 1'b0;
         tmo_err_q       <= 1'b0;
         readdata_q      <= '0;
      end else begin
         if (wr_ctrl) begin
            req_sel_q <= bus.writedata[CTRL_REQ_SEL];
            irq_en_q  <= bus.writedata[CTRL_IRQ_EN];
         end
         if (wr_timeout)                           timeout_q <= bus.writedata[CNT_W-1:0];
         if (wr_status && bus.writedata[STAT_DONE]) done_q    <= 1'b0;
         if (wr_status && bus.writedata[STAT_TMO])  tmo_err_q <= 1'b0;
         if (rd_en)                                readdata_q <= rd_mux;

         case (state_q)
            IDLE: begin
               st_hold_q <= 1'b0;
               if (switch_req && in_frame) begin
                  state_q   <= WAIT_EOP;
                  tmo_cnt_q <= '0;
               end else if (switch_req) begin
                  state_q     <= DRAIN;
                  st_hold_q   <= 1'b1;
                  drain_cnt_q <= DW'(DRAIN_CYCLES - 1);
               end
            end
            WAIT_EOP: begin
               tmo_cnt_q <= tmo_cnt_inc;
               if (!switch_req) begin
                  state_q <= IDLE;
               end else if (eop_beat || tmo_hit) begin
                  state_q     <= DRAIN;
                  st_hold_q   <= 1'b1;
                  drain_cnt_q <= DW'(DRAIN_CYCLES - 1);
                  if (!eop_beat) tmo_err_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt_q == '0) state_q     <= SWITCH;
               else                   drain_cnt_q <= drain_cnt_q - 1'b1;
            end
            SWITCH: begin
               router_select_q <= req_sel_q;
               done_q          <= 1'b1;
               st_hold_q       <= 1'b0;
               state_q         <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.readdata      = readdata_q;
   assign bus.st_hold       = st_hold_q;
   assign bus.router_select = router_select_q;
   assign bus.irq           = irq_en_q & (done_q | tmo_err_q);

endmodule

// File: doc/edge_router_sequencer.md
Name: edge_router_sequencer

Overview:
- Avalon-MM controlled sequencer for the edge-detection router select (bypass vs. edge-detect path) in the video-in subsystem.
- Software writes a requested path. The block applies it only at a frame boundary: it waits for end-of-packet, holds the upstream stream, and drains the edge-detection pipeline before flipping router_select. This prevents torn frames.
- Reports status, per-path frame counts and a completion interrupt.

Parameters:
DRAIN_CYCLES, 16, cycles to hold upstream after EOP before switching (covers edge-detect pipeline latency)
CNT_W, 16, width of frame counter and timeout counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
address  in  2  Avalon-MM word address
chipselect  in  1  slave select
read  in  1  read strobe
write  in  1  write strobe
writedata  in  32  write data
readdata  out  32  read data, registered, valid the cycle after read
st_valid  in  1  monitored upstream Avalon-ST valid
st_ready  in  1  monitored upstream Avalon-ST ready
st_sop  in  1  monitored startofpacket
st_eop  in  1  monitored endofpacket
st_hold  out  1  1 = gate upstream (forces ready low / valid low at router input)
router_select  out  1  0 = bypass, 1 = edge-detect path
irq  out  1  level interrupt

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). On reset:
  - router_select=0, st_hold=0, irq=0, readdata=0.
  - All registers 0, FSM=IDLE, in_frame=0.
- Beat definition: beat = st_valid & st_ready.
- in_frame tracking:
  - Set on a beat with sop.
  - Cleared on a beat with eop.
  - sop&eop on the same beat leaves in_frame=0.
- Register map (address):
  - 0 CTRL, RW: bit0 req_sel, bit1 irq_en.
  - 1 STATUS, R / W1C:
    - bit0 active_sel = router_select
    - bit1 pending = FSM != IDLE
    - bit2 done, W1C
    - bit3 timeout_err, W1C
  - 2 FRAMES, RO: eop beats since last switch. CNT_W bits, saturating at all-ones. Cleared at switch.
  - 3 TIMEOUT, RW: CNT_W bits. Max cycles to wait in WAIT_EOP; 0 = wait forever.
- Writes to CTRL while FSM != IDLE are accepted. The new req_sel is re-evaluated on return to IDLE.
- irq = irq_en & (done | timeout_err).
- FSM states and transitions:
  - IDLE:
    - If req_sel != router_select and in_frame=0 -> DRAIN. Assert st_hold next cycle and load drain counter.
    - If req_sel != router_select and in_frame=1 -> WAIT_EOP. Load timeout counter.
  - WAIT_EOP:
    - On a beat with eop -> DRAIN.
    - Else if TIMEOUT != 0 and the counter reaches TIMEOUT -> DRAIN, set timeout_err (torn frame accepted).
    - If req_sel returns equal to router_select before the EOP -> IDLE, no switch, no done.
  - DRAIN:
    - st_hold=1; counts DRAIN_CYCLES cycles -> SWITCH.
    - EOP arriving in the same cycle the hold asserts is still counted for FRAMES.
  - SWITCH (1 cycle):
    - router_select <= req_sel; FRAMES <= 0; done <= 1; st_hold stays 1 -> IDLE.
    - st_hold deasserts in the IDLE cycle that follows.
- Switch latency with in_frame=0: st_hold rises 1 cycle after the CTRL write is observed in IDLE; router_select changes DRAIN_CYCLES+1 cycles after st_hold rises.
- Simultaneous W1C write and set of done in the same cycle: set wins.
- Reset mid-operation: returns to IDLE, router_select=0, hold released the next cycle.
- Only one switch is in flight at a time. No queueing of multiple requests.

Decomposition:
- Shared package contents:
  - Register address constants: CTRL=0, STATUS=1, FRAMES=2, TIMEOUT=3.
  - STATUS bit indices.
  - FSM state enum: IDLE, WAIT_EOP, DRAIN, SWITCH.
- One natural sub-module, stream_frame_tracker: in_frame flag, eop pulse, saturating frame counter.

Test Plan:
- Reset then read all 4 addresses -> all 0; router_select=0, st_hold=0, irq=0.
- Stream idle (in_frame=0), DRAIN_CYCLES=16, write CTRL=0x3 -> st_hold high for 17 cycles; router_select=1 at cycle 18; STATUS=0x5; irq=1; write STATUS=0x4 -> irq=0.
- sop beat, then write CTRL=1, then eop beat 100 cycles later -> st_hold stays 0 until the cycle after the eop beat; FRAMES reads 0 after the switch.
- TIMEOUT=50, sop with no eop, write CTRL=1 -> switch starts at cycle 50; STATUS bit3=1, bit2=1 after the switch.
- In WAIT_EOP, write CTRL=0 before eop -> FSM returns to IDLE; router_select stays 0; done=0; st_hold never asserted.
- 3 complete frames with no switch pending -> FRAMES=3. Force 2^CNT_W+5 frames -> FRAMES saturates at 0xFFFF.
